// File: rtl/serial_charmatrix.sv
// serial_charmatrix: UART-fed 8x8 frame buffer driving a row-multiplexed
// LED matrix. Each received byte fills one row; rows fill 0..7 and wrap.
module serial_charmatrix #(
    parameter int CLK_HZ   = 10_000_000,
    parameter int BAUD     = 115_200,
    parameter int SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam int SW   = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4], ui_in[2]};

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       rx;
    logic       clr;
    logic       blank;

    // Two-flop synchronizers; left unreset so blank still acts during reset.
    always_ff @(posedge clk) begin
        sync1_q <= {ui_in[3], ui_in[1], ui_in[0]};
        sync2_q <= sync1_q;
    end

    assign rx    = sync2_q[2];
    assign clr   = sync2_q[1];
    assign blank = sync2_q[0];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            strobe_q, strobe_d;

    logic [7:0][7:0] fb_q, fb_d;
    logic [2:0]      wr_q, wr_d;
    logic [2:0]      idx;
    logic [SW-1:0]   scan_q, scan_d;
    logic [2:0]      row_q, row_d;
    logic [7:0]      uo_q, uo_d;
    logic [7:0]      uio_q, uio_d;

    // UART receiver next-state: mid-bit sampling, LSB first, stop check.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        strobe_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d    = '0;
                    strobe_d = rx;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame buffer write, row scan and registered display outputs.
    always_comb begin
        fb_d   = fb_q;
        wr_d   = wr_q;
        idx    = clr ? 3'd0 : wr_q;
        scan_d = scan_q + 1'b1;
        row_d  = row_q;
        if (clr) wr_d = 3'd0;
        if (strobe_q) begin
            fb_d[idx] = shift_q;
            wr_d      = idx + 3'd1;
        end
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            row_d  = row_q + 3'd1;
        end
        uo_d  = blank ? 8'h00 : fb_q[row_q];
        uio_d = blank ? 8'h00 : (8'b1 << row_q);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            strobe_q <= 1'b0;
            fb_q     <= '0;
            wr_q     <= '0;
            scan_q   <= '0;
            row_q    <= '0;
            uo_q     <= 8'h00;
            uio_q    <= blank ? 8'h00 : 8'h01;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            strobe_q <= strobe_d;
            fb_q     <= fb_d;
            wr_q     <= wr_d;
            scan_q   <= scan_d;
            row_q    <= row_d;
            uo_q     <= uo_d;
            uio_q    <= uio_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_serial_charmatrix.sv
// tb_serial_charmatrix: drives UART frames and control pins, compares the
// display outputs every cycle against a frame/scan-level reference model.
module tb_serial_charmatrix;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h08;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_charmatrix dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    localparam int BIT = 86;
    localparam int SCAN = 1024;

    // Reference model: frame buffer contents and write pointer.
    logic [7:0] fbm [8];
    int         wrp = 0;
    bit         clr_m = 0;
    bit         armed = 0;
    int         unmask_at = 0;

    // Cycle bookkeeping owned by the compare process.
    int cyc = 0;
    int k = 0;
    bit h0 = 0, h1 = 0, h2 = 0;

    // Every cycle: row = edges since reset / SCAN_DIV, shown one cycle late;
    // blank acts three edges after it is applied.
    always @(posedge clk) begin
        int         row;
        logic [7:0] e_uio;
        logic [7:0] e_uo;
        cyc = cyc + 1;
        h2 = h1;
        h1 = h0;
        h0 = ui_in[0];
        if (rst_n) k = 0;
        else k = k + 1;
        #1;
        if (armed) begin
            row = (k == 0) ? 0 : ((k - 1) / SCAN) % 8;
            e_uio = h2 ? 8'h00 : (8'h01 << row);
            e_uo = (h2 || k == 0) ? 8'h00 : fbm[row];
            checks++;
            if (uio_out !== e_uio) begin
                failures++;
                $display("FAIL uio_out cyc=%0d got=%h exp=%h", cyc, uio_out, e_uio);
            end
            checks++;
            if (uio_oe !== 8'hFF) begin
                failures++;
                $display("FAIL uio_oe cyc=%0d got=%h exp=ff", cyc, uio_oe);
            end
            if (cyc >= unmask_at) begin
                checks++;
                if (uo_out !== e_uo) begin
                    failures++;
                    $display("FAIL uo_out cyc=%0d row=%0d got=%h exp=%h",
                             cyc, row, uo_out, e_uo);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) fbm[i] = 8'h00;
        wrp = 0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        int idx;
        ui_in[3] = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ui_in[3] = b[i];
            repeat (BIT) @(negedge clk);
        end
        unmask_at = cyc + 100;
        if (good) begin
            idx = clr_m ? 0 : wrp;
            fbm[idx] = b;
            wrp = clr_m ? 0 : (idx + 1) % 8;
            ui_in[3] = 1'b1;
            repeat (BIT) @(negedge clk);
        end else begin
            ui_in[3] = 1'b0;
            repeat (60) @(negedge clk);
            ui_in[3] = 1'b1;
            repeat (26) @(negedge clk);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic check_row(input int r, input logic [7:0] exp);
        int n;
        logic [7:0] sel;
        n = 0;
        sel = 8'h01 << r;
        while (uio_out !== sel && n < 9000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 9000) begin
            failures++;
            $display("FAIL row%0d_wait got=%h exp=%h", r, uio_out, sel);
        end else if (uo_out !== exp) begin
            failures++;
            $display("FAIL row%0d_data got=%h exp=%h", r, uo_out, exp);
        end
    endtask

    initial begin
        logic [7:0] rb;
        uio_in = 8'($urandom);
        for (int i = 0; i < 8; i++) fbm[i] = 8'h00;
        repeat (4) @(negedge clk);
        armed = 1;
        rst_n = 1'b0;

        // Idle line: blank display, row select steps every SCAN_DIV cycles.
        repeat (1030) @(negedge clk);
        lit("scan_row1", uio_out, 8'h02);
        lit("idle_uo", uo_out, 8'h00);
        repeat (7168) @(negedge clk);
        lit("scan_wrap", uio_out, 8'h01);
        repeat (1800) @(negedge clk);

        // Two bytes land in rows 0 and 1.
        send_frame(8'hA5, 1);
        send_frame(8'h3C, 1);
        lit("model_r0", fbm[0], 8'hA5);
        check_row(0, 8'hA5);
        check_row(1, 8'h3C);

        // Nine bytes wrap the write pointer.
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1);
        lit("model_wrap_r0", fbm[0], 8'h09);
        lit("model_wrap_r7", fbm[7], 8'h08);
        check_row(0, 8'h09);

        // Framing error discarded; next good byte goes to row 1.
        send_frame(8'hFF, 0);
        send_frame(8'h81, 1);
        lit("model_after_ferr", fbm[1], 8'h81);
        check_row(1, 8'h81);

        // Short glitch ignored; pointer clear redirects to row 0.
        ui_in[3] = 1'b0;
        repeat (20) @(negedge clk);
        ui_in[3] = 1'b1;
        repeat (100) @(negedge clk);
        ui_in[1] = 1'b1;
        clr_m = 1;
        wrp = 0;
        repeat (5) @(negedge clk);
        send_frame(8'h7E, 1);
        repeat (10) @(negedge clk);
        ui_in[1] = 1'b0;
        clr_m = 0;
        lit("model_clr_r0", fbm[0], 8'h7E);
        check_row(0, 8'h7E);

        // Random bytes with random blank pulses and gaps.
        for (int n = 0; n < 8; n++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                ui_in[0] = 1'b1;
                repeat ($urandom_range(1, 40)) @(negedge clk);
                ui_in[0] = 1'b0;
            end
            send_frame(rb, 1);
            repeat ($urandom_range(0, 300)) @(negedge clk);
        end

        // Blank takes effect within three cycles.
        ui_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        lit("blank_uo", uo_out, 8'h00);
        lit("blank_uio", uio_out, 8'h00);
        repeat (50) @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (200) @(negedge clk);

        // Reset in the middle of a byte drops it and clears the buffer.
        ui_in[3] = 1'b0;
        repeat (4 * BIT) @(negedge clk);
        ui_in[3] = 1'b1;
        do_reset();
        repeat (1000) @(negedge clk);
        check_row(0, 8'h00);
        repeat (20) @(negedge clk);

        armed = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
